// File: rtl/dlib_pkg.sv
// rtl/dlib_pkg.sv - shared types and constants for the dlib pipeline library
package dlib_pkg;

  typedef enum logic [1:0] {
    SKID_EMPTY = 2'd0,
    SKID_BUSY  = 2'd1,
    SKID_FULL  = 2'd2
  } skid_state_e;

  localparam int SKID_DEPTH = 2;

endpackage

// File: rtl/dlib_dff_en.sv
// rtl/dlib_dff_en.sv - enable-gated register with asynchronous active-high reset to zero
module dlib_dff_en #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] val_q;
  logic [WIDTH-1:0] val_d;

  always_comb begin
    val_d = val_q;
    if (en) val_d = d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) val_q <= '0;
    else     val_q <= val_d;
  end

  assign q = val_q;

endmodule

// File: rtl/dlib_skid_buf.sv
// rtl/dlib_skid_buf.sv - two-entry fully registered valid/ready skid buffer
// Optional synchronous flush port enabled by DLIB_SKID_BUF_FLUSH_EN.
module dlib_skid_buf
  import dlib_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
`ifdef DLIB_SKID_BUF_FLUSH_EN
  input  logic             flush,
`endif
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  skid_state_e      state_q, state_d;
  logic             in_ready_q, in_ready_d;
  logic             in_fire, out_fire;
  logic             main_en, skid_en, main_from_skid;
  logic [WIDTH-1:0] main_din, skid_q;

  assign out_valid = (state_q != SKID_EMPTY);
  assign in_ready  = in_ready_q;
  assign in_fire   = in_valid & in_ready_q;
  assign out_fire  = out_valid & out_ready;
  assign main_din  = main_from_skid ? skid_q : in_data;

  always_comb begin
    state_d        = state_q;
    main_en        = 1'b0;
    skid_en        = 1'b0;
    main_from_skid = 1'b0;
    case (state_q)
      SKID_EMPTY: begin
        if (in_fire) begin
          main_en = 1'b1;
          state_d = SKID_BUSY;
        end
      end
      SKID_BUSY: begin
        if (in_fire && out_fire) begin
          main_en = 1'b1;
        end else if (in_fire) begin
          skid_en = 1'b1;
          state_d = SKID_FULL;
        end else if (out_fire) begin
          state_d = SKID_EMPTY;
        end
      end
      SKID_FULL: begin
        if (out_fire) begin
          main_en        = 1'b1;
          main_from_skid = 1'b1;
          state_d        = SKID_BUSY;
        end
      end
      default: state_d = SKID_EMPTY;
    endcase
`ifdef DLIB_SKID_BUF_FLUSH_EN
    // Flush wins over any handshake on the same edge; stored data is left untouched.
    if (flush) begin
      state_d = SKID_EMPTY;
      main_en = 1'b0;
      skid_en = 1'b0;
    end
`endif
    in_ready_d = (state_d != SKID_FULL);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= SKID_EMPTY;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
    end
  end

  dlib_dff_en #(.WIDTH(WIDTH)) u_main (
    .clk (clk),
    .rst (rst),
    .en  (main_en),
    .d   (main_din),
    .q   (out_data)
  );

  dlib_dff_en #(.WIDTH(WIDTH)) u_skid (
    .clk (clk),
    .rst (rst),
    .en  (skid_en),
    .d   (in_data),
    .q   (skid_q)
  );

endmodule

// File: tb/tb_dlib_skid_buf.sv
// tb/tb_dlib_skid_buf.sv - directed and scoreboard bench for dlib_skid_buf
// Exercises the flush path when DLIB_SKID_BUF_FLUSH_EN is defined.
module tb_dlib_skid_buf;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_data = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_data;
`ifdef DLIB_SKID_BUF_FLUSH_EN
  logic             flush = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dlib_skid_buf #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
`ifdef DLIB_SKID_BUF_FLUSH_EN
    .flush     (flush),
`endif
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  typedef struct {
    logic             iv;
    logic             ordy;
    logic [WIDTH-1:0] din;
    logic             exp_ov;
    logic             exp_ir;
    logic [WIDTH-1:0] exp_od;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic iv, input logic ordy, input logic [WIDTH-1:0] din);
    in_valid  = iv;
    out_ready = ordy;
    in_data   = din;
  endtask

  // Inputs are applied 1ns after an edge; this advances one clock and samples just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [WIDTH-1:0] sb[$];
    logic             m_in_ready;
    logic             iv_r, or_r;
    logic [WIDTH-1:0] d_r;

    vecs[0]  = '{1'b1, 1'b0, 32'hA, 1'b1, 1'b1, 32'hA};
    vecs[1]  = '{1'b1, 1'b0, 32'hB, 1'b1, 1'b0, 32'hA};
    vecs[2]  = '{1'b1, 1'b0, 32'hC, 1'b1, 1'b0, 32'hA};
    vecs[3]  = '{1'b1, 1'b1, 32'hC, 1'b1, 1'b1, 32'hB};
    vecs[4]  = '{1'b1, 1'b1, 32'hC, 1'b1, 1'b1, 32'hC};
    vecs[5]  = '{1'b0, 1'b1, 32'h0, 1'b0, 1'b1, 32'hC};
    vecs[6]  = '{1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hC};
    vecs[7]  = '{1'b1, 1'b1, 32'hD, 1'b1, 1'b1, 32'hD};
    vecs[8]  = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'hD};
    vecs[9]  = '{1'b1, 1'b0, 32'hE, 1'b1, 1'b0, 32'hD};
    vecs[10] = '{1'b0, 1'b1, 32'h0, 1'b1, 1'b1, 32'hE};
    vecs[11] = '{1'b0, 1'b1, 32'h0, 1'b0, 1'b1, 32'hE};

    #2;
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_in_ready", {31'd0, in_ready}, 32'd0);
    chk("reset_out_data", out_data, 32'd0);
    step();
    #2 rst = 1'b0;
    chk("post_release_in_ready_low", {31'd0, in_ready}, 32'd0);
    @(posedge clk);
    #1;
    chk("first_edge_in_ready", {31'd0, in_ready}, 32'd1);

    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].iv, vecs[i].ordy, vecs[i].din);
      step();
      chk($sformatf("vec%0d_out_valid", i), {31'd0, out_valid}, {31'd0, vecs[i].exp_ov});
      chk($sformatf("vec%0d_in_ready", i), {31'd0, in_ready}, {31'd0, vecs[i].exp_ir});
      chk($sformatf("vec%0d_out_data", i), out_data, vecs[i].exp_od);
    end

    for (int k = 1; k <= 16; k++) begin
      drive(1'b1, 1'b1, WIDTH'(k));
      step();
      chk($sformatf("stream%0d_out_data", k), out_data, WIDTH'(k));
      chk($sformatf("stream%0d_out_valid", k), {31'd0, out_valid}, 32'd1);
      chk($sformatf("stream%0d_in_ready", k), {31'd0, in_ready}, 32'd1);
    end
    drive(1'b0, 1'b1, '0);
    step();
    chk("stream_drain_out_valid", {31'd0, out_valid}, 32'd0);

    sb.delete();
    for (int c = 0; c < 1000; c++) begin
      iv_r = 1'($urandom_range(0, 1));
      or_r = 1'($urandom_range(0, 1));
      d_r  = $urandom;
      drive(iv_r, or_r, d_r);
      m_in_ready = (sb.size() < 2);
      if (or_r && sb.size() > 0) void'(sb.pop_front());
      if (iv_r && m_in_ready) sb.push_back(d_r);
      step();
      chk("rand_out_valid", {31'd0, out_valid}, {31'd0, (sb.size() > 0)});
      chk("rand_in_ready", {31'd0, in_ready}, {31'd0, (sb.size() < 2)});
      if (sb.size() > 0) chk("rand_out_data", out_data, sb[0]);
    end

    drive(1'b0, 1'b1, '0);
    step();
    step();
    chk("rand_drained", {31'd0, out_valid}, 32'd0);

    drive(1'b1, 1'b0, 32'h55);
    step();
    drive(1'b1, 1'b0, 32'h66);
    step();
    chk("full_in_ready", {31'd0, in_ready}, 32'd0);
    chk("full_out_data", out_data, 32'h55);
    #3 rst = 1'b1;
    #1;
    chk("midreset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midreset_in_ready", {31'd0, in_ready}, 32'd0);
    chk("midreset_out_data", out_data, 32'd0);
    drive(1'b0, 1'b0, '0);
    step();
    rst = 1'b0;
    step();
    chk("midreset_release_in_ready", {31'd0, in_ready}, 32'd1);
    chk("midreset_release_empty", {31'd0, out_valid}, 32'd0);
    drive(1'b1, 1'b1, 32'h77);
    step();
    chk("after_reset_first_word", out_data, 32'h77);
    drive(1'b0, 1'b1, '0);
    step();
    chk("after_reset_drain", {31'd0, out_valid}, 32'd0);

`ifdef DLIB_SKID_BUF_FLUSH_EN
    drive(1'b1, 1'b0, 32'hA0);
    step();
    drive(1'b1, 1'b0, 32'hA1);
    step();
    chk("flush_pre_full", {31'd0, in_ready}, 32'd0);
    drive(1'b1, 1'b1, 32'hFF);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
    chk("flush_in_ready", {31'd0, in_ready}, 32'd1);
    chk("flush_data_kept", out_data, 32'hA0);
    drive(1'b0, 1'b0, '0);
    step();
    chk("flush_next_out_valid", {31'd0, out_valid}, 32'd0);
    drive(1'b1, 1'b1, 32'h12);
    step();
    chk("flush_resume_data", out_data, 32'h12);
    chk("flush_resume_valid", {31'd0, out_valid}, 32'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
